seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
Reads a time-multiplexed, common-anode seven-segment display bus (segment lines plus active-low digit anodes) and converts it back to BCD digits. Each anode dwell is debounced. The segment pattern is decoded with the exact inverse of the team's common-anode encoding table. Once every digit position has been captured, the block emits one multi-digit frame over a valid/ready handshake. It is used for display loopback checking and for capturing a display bus from another board.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (anode lines)
STABLE_CYCLES, 4, consecutive identical samples needed to accept a digit (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
seg  input  7  segment lines, active-low, bit6=g .. bit0=a
an  input  NUM_DIGITS  anode selects, active-low; an[i]=0 selects digit i
frame_digits  output  4*NUM_DIGITS  digit i at [4i+3:4i]; 4'hF for blank or invalid
frame_blank  output  NUM_DIGITS  digit i was blank (all segments off)
frame_err  output  NUM_DIGITS  digit i held a non-decodable pattern
frame_valid  output  1  frame available
frame_ready  input  1  consumer accepts the frame
overrun  output  1  sticky; a completed frame was dropped

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset values: frame_digits=0, frame_blank=0, frame_err=0, frame_valid=0, overrun=0. The internal seen-mask, the stability counter and the input register are also cleared, and the state machine goes to COLLECT.
- Input stage: {an, seg} is registered once. All later logic uses the registered copy (s_an, s_seg).
- Stability counter:
  - If s_an is not one-hot-low (all high, or more than one low), the counter is 0 and nothing is accepted.
  - If s_an is one-hot-low and {s_an, s_seg} equals the previous cycle's registered value, the counter increments and saturates at STABLE_CYCLES.
  - Otherwise the counter is set to 1.
- Accept: a one-cycle event on the cycle the counter reaches STABLE_CYCLES. There is exactly one accept per dwell. A dwell shorter than STABLE_CYCLES is ignored.
- Decode (s_seg to digit, in hex):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F gives blank=1, digit=F.
  - Any other pattern gives err=1, digit=F.
- On accept of digit i:
  - Write {digit, blank, err} into shadow slot i and set seen[i].
  - Re-accepting the same digit before the frame completes overwrites the slot; the latest value wins.
  - Digits may arrive in any order.
- Frame complete: the accept cycle on which seen becomes all ones.
- State machine:
  - COLLECT (frame_valid=0): on frame complete, copy the shadow into the output registers, clear seen and go to PENDING. frame_valid is 1 from the next cycle, so latency is 1 cycle after the completing accept.
  - PENDING (frame_valid=1): outputs stay frozen while frame_ready=0. Collection into the shadow continues.
  - PENDING, frame complete while frame_ready=0: the new frame is discarded, seen is cleared, overrun is set to 1 and the state stays PENDING.
  - PENDING, frame_ready=1 with no completion that cycle: go to COLLECT; frame_valid=0 next cycle.
  - PENDING, frame_ready=1 in the same cycle as a frame complete: load the new frame, stay in PENDING, frame_valid stays 1, overrun unchanged.
- overrun is cleared only by rst.
- rst asserted mid-frame clears all state immediately, without waiting for a clock edge. The partial shadow is discarded.

Decomposition:
- Shared package seven_seg_pkg:
  - typedef seg_t (logic [6:0]) and digit_t (logic [3:0]).
  - Constants SEG_0..SEG_9 and SEG_BLANK (7F), shared with the existing encoder so both directions use one table.
  - DIGIT_NONE (4'hF).
- One combinational sub-module, seven_seg_pattern_decode: seg_t in; digit_t, blank and err out.
- The top level holds the input register, stability counter, shadow slots, seen-mask and the state machine.

Test Plan:
1. Reset, frame_ready=1. Drive each for 4 cycles: an=1110/seg=79, an=1101/seg=24, an=1011/seg=30, an=0111/seg=19. Expect frame_valid=1 for one cycle, 1 cycle after the 4th accept; frame_digits=16'h4321, frame_blank=0, frame_err=0.
2. Glitch: an=1110/seg=40 for only 3 cycles, then an=1111. Expect no accept and seen[0] still 0; frame_valid never asserts.
3. Full scan with digit2 seg=7E and digit3 seg=7F, digits 0 and 1 = 5 and 9. Expect frame_err=0100, frame_blank=1000, frame_digits=16'hFF95.
4. Backpressure: frame_ready=0, complete frame A (0x1234) then frame B (0x5678). Expect outputs stay 0x1234 with frame_valid=1 and overrun=1. Raise frame_ready for one cycle; frame_valid=0 next cycle and overrun stays 1.
5. Simultaneous: PENDING with frame 0x1111; frame_ready=1 on the same cycle frame 0x2222 completes. Expect frame_valid stays 1, frame_digits=0x2222 next cycle, overrun=0.
6. Assert rst asynchronously (mid-cycle) after two digits accepted. Expect all outputs 0 at once. After release, only a full 4-digit scan produces a frame.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared seven-segment types and the common-anode pattern
//                table. The encoder and the scan decoder both use this table,
//                so the two directions cannot drift apart.
//                Segment order is bit6=g .. bit0=a. A segment is lit when its
//                bit is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] digit_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_BLANK = 7'h7F;

    // Digit code reported for blank or undecodable positions
    localparam digit_t DIGIT_NONE = 4'hF;

    // Frame state machine encoding
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pattern_decode
//  Description : Combinational inverse of the common-anode segment table.
//                Ports:
//                  seg   - segment pattern, active-low, bit6=g .. bit0=a
//                  digit - BCD digit, DIGIT_NONE for blank or invalid
//                  blank - all segments off
//                  err   - pattern is neither a digit nor blank
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  seg_t   seg,
    output digit_t digit,
    output logic   blank,
    output logic   err
);

    always_comb begin
        digit = DIGIT_NONE;
        blank = 1'b0;
        err   = 1'b0;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   err   = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_decoder
//  Description : Recovers BCD digits from a multiplexed common-anode display
//                bus. Each anode dwell must stay stable for STABLE_CYCLES
//                samples before the digit is captured. Once every position
//                has been captured, a frame is offered on a valid/ready
//                handshake.
//                Ports:
//                  clk, rst     - clock, asynchronous active-high reset
//                  seg          - segment lines, active-low
//                  an           - anode selects, active-low (an[i]=0 -> digit i)
//                  frame_digits - digit i at [4i+3:4i]
//                  frame_blank  - per-digit blank flag
//                  frame_err    - per-digit undecodable flag
//                  frame_valid  - frame available
//                  frame_ready  - consumer takes the frame
//                  overrun      - sticky, a completed frame was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int                    c_cnt_w   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_max = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0]    c_cnt_pre = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one = c_cnt_w'(1);
    localparam logic [NUM_DIGITS-1:0] c_an_one  = NUM_DIGITS'(1);

    // Input register and its one-cycle-older copy for the stability compare
    logic [NUM_DIGITS-1:0]   r_an, r_an_d;
    seg_t                    r_seg, r_seg_d;

    logic [c_cnt_w-1:0]      r_cnt, w_cnt_next;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_onehot, w_same, w_accept, w_complete;

    digit_t                  w_dec_digit;
    logic                    w_dec_blank, w_dec_err;

    logic [4*NUM_DIGITS-1:0] r_sh_digits, w_new_digits;
    logic [NUM_DIGITS-1:0]   r_sh_blank, w_new_blank;
    logic [NUM_DIGITS-1:0]   r_sh_err, w_new_err;
    logic [NUM_DIGITS-1:0]   r_seen;

    state_t                  r_state, w_state_next;
    logic                    w_load, w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an    <= '0;
            r_seg   <= '0;
            r_an_d  <= '0;
            r_seg_d <= '0;
        end else begin
            r_an    <= an;
            r_seg   <= seg;
            r_an_d  <= r_an;
            r_seg_d <= r_seg;
        end
    end

    // Selected position as a high-true mask; valid only when exactly one bit is set
    assign w_sel    = ~r_an;
    assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - c_an_one)) == '0);
    assign w_same   = (r_an == r_an_d) && (r_seg == r_seg_d);

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_onehot) begin
            w_cnt_next = '0;
        end else if (w_same) begin
            if (r_cnt != c_cnt_max) begin
                w_cnt_next = r_cnt + c_cnt_one;
            end
        end else begin
            w_cnt_next = c_cnt_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Fires on the single cycle where the counter steps up to its ceiling;
    // saturation keeps a long dwell from re-accepting.
    assign w_accept = w_onehot && w_same && (r_cnt == c_cnt_pre);

    seven_seg_pattern_decode u_decode (
        .seg   (r_seg),
        .digit (w_dec_digit),
        .blank (w_dec_blank),
        .err   (w_dec_err)
    );

    // Shadow contents including this cycle's accept, so a completing
    // accept lands in the output registers on the same edge.
    always_comb begin
        w_new_digits = r_sh_digits;
        w_new_blank  = r_sh_blank;
        w_new_err    = r_sh_err;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_accept && w_sel[i]) begin
                w_new_digits[4*i +: 4] = w_dec_digit;
                w_new_blank[i]         = w_dec_blank;
                w_new_err[i]           = w_dec_err;
            end
        end
    end

    assign w_complete = w_accept && ((r_seen | w_sel) == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_digits <= '0;
            r_sh_blank  <= '0;
            r_sh_err    <= '0;
            r_seen      <= '0;
        end else begin
            r_sh_digits <= w_new_digits;
            r_sh_blank  <= w_new_blank;
            r_sh_err    <= w_new_err;
            if (w_complete) begin
                r_seen <= '0;
            end else if (w_accept) begin
                r_seen <= r_seen | w_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_complete) begin
                    // A consumer taking the old frame this cycle frees the
                    // output registers for the new one; otherwise it is lost.
                    if (frame_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (frame_ready) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_digits <= '0;
            frame_blank  <= '0;
            frame_err    <= '0;
            overrun      <= 1'b0;
        end else begin
            if (w_load) begin
                frame_digits <= w_new_digits;
                frame_blank  <= w_new_blank;
                frame_err    <= w_new_err;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign frame_valid = (r_state == ST_PENDING);

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_decoder
//  Description : Self-checking bench for seven_seg_scan_decoder. Expected
//                frames are queued as each scan is driven and compared when
//                the DUT hands a frame over (frame_valid & frame_ready).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] frame_digits;
    logic [3:0]  frame_blank;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    // {digits[15:0], blank[3:0], err[3:0]}
    logic [23:0] sb_q[$];

    seven_seg_scan_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg          (seg),
        .an           (an),
        .frame_digits (frame_digits),
        .frame_blank  (frame_blank),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Independent copy of the common-anode table
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    // Returns #1 after the last sampling edge, i.e. inside the accept cycle
    task automatic drive_digit(input int pos, input logic [6:0] s, input int cyc);
        an  = ~(4'b0001 << pos);
        seg = s;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cyc);
        an  = 4'hF;
        seg = 7'h7F;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [15:0] digs);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            drive_digit(i, enc(digs[4*i +: 4]), STABLE_CYCLES);
        end
    endtask

    // Handshake monitor: transfer happens at the next rising edge
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            chk("sb_frame_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                chk("sb_frame", 32'({frame_digits, frame_blank, frame_err}), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        an          = 4'hF;
        seg         = 7'h7F;
        frame_ready = 1'b1;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_digits",  32'(frame_digits), 32'h0);
        chk("reset_blank",   32'(frame_blank),  32'h0);
        chk("reset_err",     32'(frame_err),    32'h0);
        chk("reset_valid",   32'(frame_valid),  32'h0);
        chk("reset_overrun", 32'(overrun),      32'h0);
        rst = 1'b0;
        idle(2);

        // Basic frame and output latency
        sb_q.push_back({16'h4321, 4'h0, 4'h0});
        scan(16'h4321);
        chk("t1_valid_at_accept", 32'(frame_valid), 32'h0);
        @(posedge clk); #1;
        chk("t1_valid_latency", 32'(frame_valid), 32'h1);
        chk("t1_digits", 32'(frame_digits), 32'h4321);
        @(posedge clk); #1;
        chk("t1_valid_one_cycle", 32'(frame_valid), 32'h0);
        idle(3);

        // Short dwell on digit 0 must not mark it seen
        drive_digit(0, 7'h40, STABLE_CYCLES - 1);
        idle(2);
        drive_digit(1, enc(4'd6), STABLE_CYCLES);
        drive_digit(2, enc(4'd7), STABLE_CYCLES);
        drive_digit(3, enc(4'd8), STABLE_CYCLES);
        @(posedge clk); #1;
        chk("t2_glitch_ignored", 32'(frame_valid), 32'h0);
        idle(2);
        sb_q.push_back({16'h8760, 4'h0, 4'h0});
        drive_digit(0, enc(4'd0), STABLE_CYCLES);
        @(posedge clk); #1;
        chk("t2_valid", 32'(frame_valid), 32'h1);
        idle(3);

        // Error and blank positions
        sb_q.push_back({16'hFF95, 4'b1000, 4'b0100});
        drive_digit(0, enc(4'd5), STABLE_CYCLES);
        drive_digit(1, enc(4'd9), STABLE_CYCLES);
        drive_digit(2, 7'h7E, STABLE_CYCLES);
        drive_digit(3, 7'h7F, STABLE_CYCLES);
        @(posedge clk); #1;
        chk("t3_digits", 32'(frame_digits), 32'hFF95);
        chk("t3_blank",  32'(frame_blank),  32'h8);
        chk("t3_err",    32'(frame_err),    32'h4);
        idle(3);

        // Backpressure: second frame dropped, overrun sticky
        frame_ready = 1'b0;
        sb_q.push_back({16'h1234, 4'h0, 4'h0});
        scan(16'h1234);
        @(posedge clk); #1;
        chk("t4_no_overrun_yet", 32'(overrun), 32'h0);
        idle(2);
        scan(16'h5678);
        @(posedge clk); #1;
        chk("t4_frozen_digits", 32'(frame_digits), 32'h1234);
        chk("t4_valid_held",    32'(frame_valid),  32'h1);
        chk("t4_overrun",       32'(overrun),      32'h1);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        chk("t4_valid_dropped", 32'(frame_valid), 32'h0);
        chk("t4_overrun_sticky", 32'(overrun),    32'h1);
        idle(2);

        // Asynchronous reset mid-frame
        drive_digit(0, enc(4'd3), STABLE_CYCLES);
        drive_digit(1, enc(4'd4), STABLE_CYCLES);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_digits",  32'(frame_digits), 32'h0);
        chk("t6_async_overrun", 32'(overrun),      32'h0);
        chk("t6_async_valid",   32'(frame_valid),  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        frame_ready = 1'b1;
        idle(2);
        drive_digit(2, enc(4'd9), STABLE_CYCLES);
        drive_digit(3, enc(4'd0), STABLE_CYCLES);
        @(posedge clk); #1;
        chk("t6_partial_discarded", 32'(frame_valid), 32'h0);
        idle(2);
        sb_q.push_back({16'h0987, 4'h0, 4'h0});
        drive_digit(0, enc(4'd7), STABLE_CYCLES);
        drive_digit(1, enc(4'd8), STABLE_CYCLES);
        @(posedge clk); #1;
        chk("t6_full_scan_valid", 32'(frame_valid), 32'h1);
        idle(3);

        // Consumer takes the old frame on the cycle a new one completes
        frame_ready = 1'b0;
        sb_q.push_back({16'h1111, 4'h0, 4'h0});
        scan(16'h1111);
        @(posedge clk); #1;
        chk("t5_first_valid", 32'(frame_valid), 32'h1);
        idle(2);
        sb_q.push_back({16'h2222, 4'h0, 4'h0});
        scan(16'h2222);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_valid_stays", 32'(frame_valid),  32'h1);
        chk("t5_new_digits",  32'(frame_digits), 32'h2222);
        chk("t5_no_overrun",  32'(overrun),      32'h0);
        @(posedge clk); #1;
        chk("t5_valid_clears", 32'(frame_valid), 32'h0);
        idle(2);

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
